alu4_ctrl: RTL and testbench
============================

# alu4_ctrl

Sequential issue controller for the 4-bit ALU datapath. Accepts register-to-register commands over a valid/ready handshake, drives the ALU's operand and opcode inputs from a 4-entry × 4-bit register file, captures the ALU result and the c/n/z/v flags, writes the result back, and returns it over a valid/ready response channel. It sits between a command source (testbench or future sequencer) and a purely combinational `alu4` instance.

## Interface

**Parameters:** none.

**Ports** (name, direction, width, meaning):

- `clk`  in  1  single clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  3  ALU opcode:
  - 000 not a, 001 not b, 010 and, 011 or;
  - 100 xor, 101 xnor, 110 add, 111 sub.
- `cmd_rd`  in  2  destination register index.
- `cmd_rs1`  in  2  source register for ALU input a.
- `cmd_rs2`  in  2  source register for ALU input b.
- `cmd_imm_sel`  in  1  1 = use `cmd_imm` as b (only with `ALU4_CTRL_IMM_EN`).
- `cmd_imm`  in  4  immediate operand.
- `alu_a`, `alu_b`  out  4 each  operands to the ALU.
- `alu_op`  out  3  opcode to the ALU.
- `alu_result`  in  4  ALU result.
- `alu_c`, `alu_n`, `alu_z`, `alu_v`  in  1 each  ALU flags.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_data`  out  4  captured result.
- `flags`  out  4  captured flags {c,n,z,v}, bit 3 = c.
- `cmd_cnt`  out  8  completed-command counter.

## Operation

- **FSM states:** IDLE, EXEC, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `alu_a`=R[rs1], `alu_b`=(imm path ? `cmd_imm` : R[rs2]), `alu_op`=`cmd_op`, and rd.
  - Transition to EXEC.
- **EXEC**
  - `cmd_ready`=0. ALU inputs are stable for the whole cycle.
  - At the end of the cycle:
    - R[rd] ← `alu_result`;
    - `rsp_data` ← `alu_result`;
    - `flags` ← {c,n,z,v};
    - `cmd_cnt` += 1.
  - Transition to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_data` and `flags` are held.
  - On `rsp_ready`, go to IDLE.
  - `cmd_valid` is ignored in this state.
- `alu_a`/`alu_b`/`alu_op` hold their last issued values outside EXEC.
- rd == rs1 or rd == rs2 is legal: operands are latched before writeback.
- `cmd_cnt` wraps from 255 to 0.
- **Reset values:**
  - state IDLE, `cmd_ready`=1, `rsp_valid`=0;
  - `rsp_data`=0, `flags`=0, `cmd_cnt`=0;
  - `alu_a`=`alu_b`=0, `alu_op`=000;
  - R0–R3=0.
- **Reset asserted in any state:** abort immediately. No writeback; the pending response is dropped.

## Timing

- Acceptance at rising edge E0 (`cmd_valid` & `cmd_ready`).
- ALU outputs are driven from E0 through E1.
- Writeback and flag capture happen at E1; `rsp_valid` rises after E1.
- Earliest response handshake is at E2; `cmd_ready` returns after E2.
- Minimum 3 cycles per command. Latency from acceptance to `rsp_valid` is exactly 1 cycle.
- `rsp_ready` held low stalls indefinitely in RESP with outputs stable.
- No combinational path from any input to any output.

## Configuration

- **`ALU4_CTRL_IMM_EN` defined:** `cmd_imm_sel`=1 selects `cmd_imm` as the b operand.
- **`ALU4_CTRL_IMM_EN` undefined:**
  - `cmd_imm_sel` and `cmd_imm` are ignored; b is always R[rs2].
  - Ports remain present.
  - Without the macro, registers can only be populated via not/logic ops from reset zeros.

## Test plan

- **Reset:** pulse `reset` → `cmd_ready`=1, `rsp_valid`=0, `flags`=0, `cmd_cnt`=0, `alu_a`=`alu_b`=0, all registers read back as 0.
- **Immediate add (IMM_EN):** op=110, rs1=0, imm_sel=1, imm=5, rd=1 → `alu_a`=0, `alu_b`=5; `rsp_valid` 1 cycle after acceptance with `rsp_data`=5, `flags`=0000; `cmd_cnt`=1.
- **Overflow:** then op=110, rs1=1, imm=4, rd=1 → `rsp_data`=9 (1001), `flags` c=0 n=1 z=0 v=1.
- **Self-subtract:** op=111, rs1=1, rs2=1, rd=2 → `rsp_data`=0, `flags` c=1 n=0 z=1 v=0; R2=0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles with `cmd_valid`=1 → `rsp_valid` stays 1, `rsp_data` stable, `cmd_ready`=0, no second acceptance; `cmd_cnt` unchanged until the handshake.
- **Reset mid-operation:** assert `reset` during EXEC of op=001 (rs2=0, rd=3) → next cycle IDLE, R3=0, `rsp_valid`=0, `cmd_cnt`=0.

Source files
------------

// File: rtl/alu4_ctrl.sv
// Issue controller for the combinational 4-bit ALU: 4x4 register file, valid/ready command and response channels.
// Optional `ALU4_CTRL_IMM_EN` enables the immediate b operand; without it b is always R[rs2].
module alu4_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs1,
  input  logic [1:0] cmd_rs2,
  input  logic       cmd_imm_sel,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_c,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_v,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic [3:0] flags,
  output logic [7:0] cmd_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t     state_q, state_d;
  logic [3:0] regs_q [4];
  logic [3:0] alu_a_q, alu_b_q;
  logic [2:0] alu_op_q;
  logic [1:0] rd_q;
  logic [3:0] rsp_data_q, flags_q;
  logic [7:0] cmd_cnt_q;
  logic [3:0] b_sel;

`ifdef ALU4_CTRL_IMM_EN
  assign b_sel = cmd_imm_sel ? cmd_imm : regs_q[cmd_rs2];
`else
  logic unused_imm;
  assign unused_imm = ^{cmd_imm_sel, cmd_imm};
  assign b_sel      = regs_q[cmd_rs2];
`endif

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Operands are latched at acceptance, so rd aliasing rs1/rs2 reads the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rd_q       <= '0;
      rsp_data_q <= '0;
      flags_q    <= '0;
      cmd_cnt_q  <= '0;
    end else begin
      if (state_q == S_IDLE && cmd_valid) begin
        alu_a_q  <= regs_q[cmd_rs1];
        alu_b_q  <= b_sel;
        alu_op_q <= cmd_op;
        rd_q     <= cmd_rd;
      end
      if (state_q == S_EXEC) begin
        regs_q[rd_q] <= alu_result;
        rsp_data_q   <= alu_result;
        flags_q      <= {alu_c, alu_n, alu_z, alu_v};
        cmd_cnt_q    <= cmd_cnt_q + 8'd1;
      end
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_data = rsp_data_q;
  assign flags    = flags_q;
  assign cmd_cnt  = cmd_cnt_q;

endmodule

// File: tb/tb_alu4_ctrl.sv
// Self-checking bench for alu4_ctrl: directed vector table, corner sequences, and random commands against a reference model.
module tb_alu4_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic       cmd_imm_sel;
  logic [3:0] cmd_imm;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_c, alu_n, alu_z, alu_v;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data, flags;
  logic [7:0] cmd_cnt;

  int checks = 0;
  int errors = 0;

  alu4_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .flags(flags), .cmd_cnt(cmd_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sx(input logic [3:0] x);
    return x[3] ? int'(x) - 16 : int'(x);
  endfunction

  // Returns {c, n, z, v, result}; c on subtract means "no borrow".
  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int r, s;
    logic c, v;
    logic [3:0] res;
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      3'd0: r = 15 - int'(a);
      3'd1: r = 15 - int'(b);
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 15 - int'(a ^ b);
      3'd6: begin
        r = int'(a) + int'(b);
        c = (r > 15);
        s = sx(a) + sx(b);
        v = (s > 7) || (s < -8);
      end
      default: begin
        r = (int'(a) - int'(b) + 16) % 16;
        c = (a >= b);
        s = sx(a) - sx(b);
        v = (s > 7) || (s < -8);
      end
    endcase
    res = 4'(r);
    return {c, res[3], (res == 4'd0), v, res};
  endfunction

  always_comb begin
    {alu_c, alu_n, alu_z, alu_v, alu_result} = alu_ref(alu_op, alu_a, alu_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic isel, input logic [3:0] imm,
                        input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] edata,
                        input logic [3:0] ef, input logic [7:0] ecnt, input int stall,
                        input string tag);
    chk({tag, "_ready_idle"}, 32'(cmd_ready), 1);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm_sel = isel; cmd_imm = imm; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, "_alu_a"}, 32'(alu_a), 32'(ea));
    chk({tag, "_alu_b"}, 32'(alu_b), 32'(eb));
    chk({tag, "_alu_op"}, 32'(alu_op), 32'(op));
    chk({tag, "_exec_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_exec_rspv"}, 32'(rsp_valid), 0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 1);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(edata));
    chk({tag, "_flags"}, 32'(flags), 32'(ef));
    chk({tag, "_cmd_cnt"}, 32'(cmd_cnt), 32'(ecnt));
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      chk({tag, "_stall_rspv"}, 32'(rsp_valid), 1);
      chk({tag, "_stall_data"}, 32'(rsp_data), 32'(edata));
      chk({tag, "_stall_flags"}, 32'(flags), 32'(ef));
      chk({tag, "_stall_ready"}, 32'(cmd_ready), 0);
      chk({tag, "_stall_cnt"}, 32'(cmd_cnt), 32'(ecnt));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_done_rspv"}, 32'(rsp_valid), 0);
    chk({tag, "_done_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_done_cnt"}, 32'(cmd_cnt), 32'(ecnt));
  endtask

  // Architectural reference state
  logic [3:0] m_regs [4];
  int         m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    m_cnt = 0;
  endtask

  task automatic model_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic isel, input logic [3:0] imm,
                           input int stall, input string tag);
    logic [3:0] a, b;
    logic [7:0] r;
    a = m_regs[rs1];
`ifdef ALU4_CTRL_IMM_EN
    b = isel ? imm : m_regs[rs2];
`else
    b = m_regs[rs2];
`endif
    r = alu_ref(op, a, b);
    m_regs[rd] = r[3:0];
    m_cnt = (m_cnt + 1) % 256;
    do_cmd(op, rd, rs1, rs2, isel, imm, a, b, r[3:0], r[7:4], 8'(m_cnt), stall, tag);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_rspv", 32'(rsp_valid), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_cnt", 32'(cmd_cnt), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [3:0] a, b, data, fl;
    int         stall;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{3'd0, 2'd1, 2'd0, 2'd0, 4'h0, 4'h0, 4'hF, 4'b0100, 0};
    tbl[1]  = '{3'd6, 2'd2, 2'd1, 2'd1, 4'hF, 4'hF, 4'hE, 4'b1100, 1};
    tbl[2]  = '{3'd7, 2'd3, 2'd1, 2'd1, 4'hF, 4'hF, 4'h0, 4'b1010, 5};
    tbl[3]  = '{3'd6, 2'd0, 2'd2, 2'd1, 4'hE, 4'hF, 4'hD, 4'b1100, 0};
    tbl[4]  = '{3'd7, 2'd3, 2'd3, 2'd1, 4'h0, 4'hF, 4'h1, 4'b0000, 0};
    tbl[5]  = '{3'd2, 2'd1, 2'd0, 2'd2, 4'hD, 4'hE, 4'hC, 4'b0100, 2};
    tbl[6]  = '{3'd4, 2'd2, 2'd1, 2'd1, 4'hC, 4'hC, 4'h0, 4'b0010, 0};
    tbl[7]  = '{3'd5, 2'd2, 2'd0, 2'd3, 4'hD, 4'h1, 4'h3, 4'b0000, 0};
    tbl[8]  = '{3'd3, 2'd0, 2'd2, 2'd1, 4'h3, 4'hC, 4'hF, 4'b0100, 0};
    tbl[9]  = '{3'd1, 2'd1, 2'd0, 2'd0, 4'hF, 4'hF, 4'h0, 4'b0010, 0};
    tbl[10] = '{3'd6, 2'd3, 2'd0, 2'd3, 4'hF, 4'h1, 4'h0, 4'b1010, 0};
    tbl[11] = '{3'd7, 2'd2, 2'd2, 2'd0, 4'h3, 4'hF, 4'h4, 4'b0000, 0};
    tbl[12] = '{3'd6, 2'd1, 2'd2, 2'd2, 4'h4, 4'h4, 4'h8, 4'b0101, 0};
    tbl[13] = '{3'd7, 2'd0, 2'd1, 2'd2, 4'h8, 4'h4, 4'h4, 4'b1001, 3};

    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm_sel = 1'b0; cmd_imm = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulse_reset();

    for (int i = 0; i < 14; i++)
      do_cmd(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, 1'b0, 4'h9,
             tbl[i].a, tbl[i].b, tbl[i].data, tbl[i].fl, 8'(i + 1), tbl[i].stall,
             $sformatf("vec%0d", i));

`ifdef ALU4_CTRL_IMM_EN
    pulse_reset();
    do_cmd(3'd6, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5, 4'd0, 4'd5, 4'd5, 4'b0000, 8'd1, 0, "imm_add");
    do_cmd(3'd6, 2'd1, 2'd1, 2'd0, 1'b1, 4'd4, 4'd5, 4'd4, 4'd9, 4'b0101, 8'd2, 0, "imm_ovf");
    do_cmd(3'd7, 2'd2, 2'd1, 2'd1, 1'b0, 4'd0, 4'd9, 4'd9, 4'd0, 4'b1010, 8'd3, 0, "self_sub");
`endif

    // Reset landing in EXEC must drop the writeback of ~R0 into R3.
    pulse_reset();
    cmd_op = 3'd1; cmd_rd = 2'd3; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_imm_sel = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    cmd_valid = 1'b0;
    #1;
    chk("midrst_rspv", 32'(rsp_valid), 0);
    chk("midrst_ready", 32'(cmd_ready), 1);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    chk("midrst_cnt", 32'(cmd_cnt), 0);
    chk("midrst_data", 32'(rsp_data), 0);
    chk("midrst_flags", 32'(flags), 0);
    do_cmd(3'd3, 2'd0, 2'd3, 2'd3, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0010, 8'd1, 0, "midrst_r3");

    pulse_reset();
    model_reset();
    for (int i = 0; i < 4; i++)
      model_cmd(3'd3, 2'(i), 2'(i), 2'(i), 1'b0, 4'd0, 0, $sformatf("rdback%0d", i));

    for (int i = 0; i < 300; i++)
      model_cmd(3'($urandom_range(7)), 2'($urandom_range(3)), 2'($urandom_range(3)),
                2'($urandom_range(3)), 1'($urandom_range(1)), 4'($urandom_range(15)),
                ($urandom_range(3) == 0) ? int'($urandom_range(1, 3)) : 0,
                $sformatf("rnd%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
